hc595_chain_driver: RTL and testbench
=====================================

Name: hc595_chain_driver

Overview:
- Parametrised serial driver for a daisy-chain of N 74HC595 shift registers, for example 7-segment or LED-bar boards.
- Accepts a parallel word with a valid/ready handshake and shifts it out MSB- or LSB-first on srclk/data_ser at a programmable rate.
- Pulses rclk to latch the word into all chips, then signals completion.
- Sits between display/control logic and the board pins; replaces the fixed 16-bit, always-enabled driver.

Parameters:
- N_CHIPS, 2, number of cascaded 74HC595 devices; data width W = 8*N_CHIPS.
- CLK_DIV, 4, sys_clk cycles per srclk half-period and per rclk high pulse; legal values are 1 or more.
- LSB_FIRST, 0, 0 shifts data_in[W-1] first; 1 shifts data_in[0] first.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  W  word to transmit; sampled only on the capture cycle.
- send_en  in  1  request; a transfer is captured when send_en and ready are both 1.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse when the latch pulse ends.
- srclk  out  1  shift clock to chip SRCLK.
- data_ser  out  1  serial data to chip SER.
- rclk  out  1  storage-latch clock to chip RCLK.
- srclr_n  out  1  shift-register clear, active low.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE.
  - srclk=0, rclk=0, data_ser=0, done=0, ready=1, srclr_n=1.
  - Bit and phase counters are cleared; any partial frame is abandoned, with no rclk pulse.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - ready=1.
  - On send_en=1 (capture cycle T0), load data_in into the shift register, set bit counter to W-1, and go to SHIFT_LO.
- SHIFT_LO:
  - srclk=0 and data_ser presents the current bit.
  - data_ser changes only on entry to SHIFT_LO, giving CLK_DIV cycles of setup before the srclk rising edge.
  - After CLK_DIV cycles, go to SHIFT_HI.
- SHIFT_HI:
  - srclk=1 and data_ser is held.
  - After CLK_DIV cycles: if the bit counter is 0, go to LATCH; otherwise decrement it, shift the register, and go to SHIFT_LO.
- LATCH:
  - srclk=0, rclk=1 for CLK_DIV cycles.
  - Then go to IDLE with done=1 and ready=1 in that same cycle.
- Timing:
  - done rises at T0 + 1 + 2*CLK_DIV*W + CLK_DIV.
  - For W=16 and CLK_DIV=4, that is T0+133.
- Back-to-back: with send_en held at 1, the next frame is captured on the done cycle. Frame period = 1 + 2*CLK_DIV*W + CLK_DIV cycles, with no gap beyond that.
- send_en while ready=0 is ignored; it is not queued.
- Changes on data_in after the capture cycle have no effect on the frame in flight.
- All outputs are registered; no combinational path from inputs to outputs.
- Counter widths are clog2 of max(W, CLK_DIV+1).

Optional Feature:
- Macro HC595_SRCLR_EN.
- Defined:
  - Adds state CLEAR between IDLE and SHIFT_LO.
  - In CLEAR, srclr_n=0 for CLK_DIV cycles, which flushes stale chain contents.
  - Latency and frame period each grow by CLK_DIV, so done rises at T0 + 1 + CLK_DIV + 2*CLK_DIV*W + CLK_DIV.
- Undefined: CLEAR does not exist and srclr_n is constant 1.

Decomposition:
- Package hc595_pkg holds:
  - The state enum (IDLE, CLEAR, SHIFT_LO, SHIFT_HI, LATCH).
  - A clog2 helper function.
  - A constant BITS_PER_CHIP=8.
- One natural sub-module: hc595_phase_tick, a CLK_DIV down-counter.
  - Restarts on every state change.
  - Issues a single-cycle phase_end strobe.
  - The FSM/shift datapath stays in the top module.

Test Plan:
- Default parameters, data_in=16'h7FC0, single send_en pulse:
  - data_ser, sampled at each of 16 srclk rising edges, reads 0,1,1,1,1,1,1,1,1,1,0,0,0,0,0,0.
  - One rclk pulse 4 cycles wide.
  - done at T0+133; ready low from T0+1 to T0+132.
- LSB_FIRST=1, N_CHIPS=3, CLK_DIV=1, data_in=24'hA5_0F_3C:
  - Sampled bit stream equals data_in[0] up to data_in[23].
  - done at T0+1+48+1 = T0+50.
- send_en held at 1 with data_in alternating 16'h0001/16'h8000 on each done:
  - Consecutive frames with period 133 cycles.
  - Each frame's bits match the word present on its capture cycle.
- send_en pulsed at T0+10 and T0+60 during a frame:
  - Ignored; exactly one rclk pulse and one done.
- rst_n asserted at T0+40 (mid-shift):
  - All outputs reach reset values asynchronously.
  - No rclk pulse; ready=1 after release; a new frame then completes correctly.
- With HC595_SRCLR_EN defined, default parameters:
  - srclr_n low for cycles T0+1 to T0+4.
  - First srclk rising edge at T0+9.
  - done at T0+137.

Source files
------------

// File: rtl/hc595_chain_driver_pkg.sv
// hc595_pkg: state encoding and sizing helpers shared by the 74HC595 chain driver.
package hc595_pkg;
   localparam int BITS_PER_CHIP = 8;
   typedef enum logic [2:0] {IDLE, CLEAR, SHIFT_LO, SHIFT_HI, LATCH} state_t;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/hc595_chain_driver_if.sv
// hc595_chain_driver_if: word/handshake bus between display logic (master) and the chain driver (slave).
interface hc595_chain_driver_if #(parameter int W = 16);
   logic [W-1:0] data_in;
   logic send_en;
   logic ready;
   logic done;
   modport master(output data_in, send_en, input ready, done);
   modport slave(input data_in, send_en, output ready, done);
endinterface

// File: rtl/hc595_chain_driver_phase_tick.sv
// hc595_phase_tick: CLK_DIV down-counter reloaded on every FSM state change; phase_end flags a phase's last cycle.
module hc595_phase_tick #(
   parameter int CLK_DIV = 4,
   parameter int CW = 3
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic restart,
   output logic phase_end
);
   logic [CW-1:0] cnt;
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (restart) cnt <= CW'(CLK_DIV - 1);
      else if (cnt != '0) cnt <= cnt - CW'(1);
   assign phase_end = (cnt == '0);
endmodule

// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver: shifts a W=8*N_CHIPS word into a 74HC595 daisy chain and pulses rclk to latch it.
// Define HC595_SRCLR_EN to add a CLEAR phase that holds srclr_n low for CLK_DIV cycles before shifting.
module hc595_chain_driver import hc595_pkg::*; #(
   parameter int N_CHIPS = 2,
   parameter int CLK_DIV = 4,
   parameter int LSB_FIRST = 0
) (
   input  logic sys_clk,
   input  logic rst_n,
   hc595_chain_driver_if.slave bus,
   output logic srclk,
   output logic data_ser,
   output logic rclk,
   output logic srclr_n
);
   localparam int W = BITS_PER_CHIP * N_CHIPS;
   localparam int CW = clog2((W > CLK_DIV + 1) ? W : CLK_DIV + 1);
   state_t state;
   logic [W-1:0] sr, nxt;
   logic [CW-1:0] bit_cnt;
   logic phase_end, restart;
   function automatic logic head(input logic [W-1:0] v);
      return (LSB_FIRST != 0) ? v[0] : v[W-1];
   endfunction
   assign nxt = (LSB_FIRST != 0) ? sr >> 1 : sr << 1;
   // the phase counter reloads exactly when the FSM leaves its current state
   assign restart = (state == IDLE) ? bus.send_en : phase_end;
   hc595_phase_tick #(.CLK_DIV(CLK_DIV), .CW(CW)) u_tick (
      .sys_clk(sys_clk),
      .rst_n(rst_n),
      .restart(restart),
      .phase_end(phase_end)
   );
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sr <= '0;
         bit_cnt <= '0;
         srclk <= 1'b0;
         rclk <= 1'b0;
         data_ser <= 1'b0;
         srclr_n <= 1'b1;
         bus.done <= 1'b0;
         bus.ready <= 1'b1;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.send_en) begin
               sr <= bus.data_in;
               bit_cnt <= CW'(W - 1);
               bus.ready <= 1'b0;
`ifdef HC595_SRCLR_EN
               state <= CLEAR;
               srclr_n <= 1'b0;
`else
               state <= SHIFT_LO;
               data_ser <= head(bus.data_in);
`endif
            end
`ifdef HC595_SRCLR_EN
            CLEAR: if (phase_end) begin
               state <= SHIFT_LO;
               srclr_n <= 1'b1;
               data_ser <= head(sr);
            end
`endif
            SHIFT_LO: if (phase_end) begin
               state <= SHIFT_HI;
               srclk <= 1'b1;
            end
            SHIFT_HI: if (phase_end) begin
               srclk <= 1'b0;
               if (bit_cnt == '0) begin
                  state <= LATCH;
                  rclk <= 1'b1;
               end else begin
                  state <= SHIFT_LO;
                  bit_cnt <= bit_cnt - CW'(1);
                  sr <= nxt;
                  data_ser <= head(nxt);
               end
            end
            LATCH: if (phase_end) begin
               state <= IDLE;
               rclk <= 1'b0;
               bus.done <= 1'b1;
               bus.ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hc595_chain_driver.sv
// tb_hc595_chain_driver: scoreboard bench for a default 16-bit MSB-first chain and a 24-bit LSB-first CLK_DIV=1 chain.
`timescale 1ns/1ps
module tb_hc595_chain_driver;
`ifdef HC595_SRCLR_EN
   localparam int XA = 4, XB = 1;
`else
   localparam int XA = 0, XB = 0;
`endif
   localparam int PA = 1 + 2 * 4 * 16 + 4 + XA;
   localparam int PB = 1 + 2 * 1 * 24 + 1 + XB;

   logic sys_clk = 1'b0, rst_n = 1'b0;
   logic a_srclk, a_ser, a_rclk, a_clr, b_srclk, b_ser, b_rclk, b_clr;
   hc595_chain_driver_if #(.W(16)) ifa ();
   hc595_chain_driver_if #(.W(24)) ifb ();

   hc595_chain_driver dut_a (
      .sys_clk(sys_clk), .rst_n(rst_n), .bus(ifa),
      .srclk(a_srclk), .data_ser(a_ser), .rclk(a_rclk), .srclr_n(a_clr)
   );
   hc595_chain_driver #(.N_CHIPS(3), .CLK_DIV(1), .LSB_FIRST(1)) dut_b (
      .sys_clk(sys_clk), .rst_n(rst_n), .bus(ifb),
      .srclk(b_srclk), .data_ser(b_ser), .rclk(b_rclk), .srclr_n(b_clr)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0, n_chk = 0, n_pass = 0;
   always @(posedge sys_clk) cyc++;

   bit exp_a[$], exp_b[$];
   int a_rw = 0, b_rw = 0, b_nrise = 0;
   int a_rw_q[$], b_rw_q[$], a_rise_q[$];
   int a_rdy_fall = -1, a_rdy_rise = -1, a_clr_fall = -1, a_clr_rise = -1;
   logic a_srclk_p = 1'b0, b_srclk_p = 1'b0, a_rdy_p = 1'b1, a_clr_p = 1'b1;

   // scoreboard: each srclk rising edge pops the next expected serial bit
   always @(negedge sys_clk) begin
      if (a_srclk && !a_srclk_p) begin
         a_rise_q.push_back(cyc);
         n_chk++;
         if (exp_a.size() == 0) $display("FAIL a_bit: unexpected shift at cycle %0d", cyc);
         else begin
            if (a_ser !== exp_a[0]) $display("FAIL a_bit: data_ser=%0b required %0b at cycle %0d", a_ser, exp_a[0], cyc);
            else n_pass++;
            exp_a.delete(0);
         end
      end
      if (b_srclk && !b_srclk_p) begin
         b_nrise++;
         n_chk++;
         if (exp_b.size() == 0) $display("FAIL b_bit: unexpected shift at cycle %0d", cyc);
         else begin
            if (b_ser !== exp_b[0]) $display("FAIL b_bit: data_ser=%0b required %0b at cycle %0d", b_ser, exp_b[0], cyc);
            else n_pass++;
            exp_b.delete(0);
         end
      end
      a_srclk_p = a_srclk;
      b_srclk_p = b_srclk;
      if (!ifa.ready && a_rdy_p) a_rdy_fall = cyc;
      if (ifa.ready && !a_rdy_p) a_rdy_rise = cyc;
      a_rdy_p = ifa.ready;
      if (!a_clr && a_clr_p) a_clr_fall = cyc;
      if (a_clr && !a_clr_p) a_clr_rise = cyc;
      a_clr_p = a_clr;
      if (a_rclk) a_rw++;
      else if (a_rw != 0) begin a_rw_q.push_back(a_rw); a_rw = 0; end
      if (b_rclk) b_rw++;
      else if (b_rw != 0) begin b_rw_q.push_back(b_rw); b_rw = 0; end
   end

   task automatic send_a(input logic [15:0] w);
      ifa.data_in = w;
      ifa.send_en = 1'b1;
      for (int i = 15; i >= 0; i--) exp_a.push_back(w[i]);
   endtask

   task automatic wait_done_a(input int limit, output int at);
      at = -1;
      for (int k = 0; k < limit && at < 0; k++) begin
         @(negedge sys_clk);
         if (ifa.done) at = cyc;
      end
   endtask

   task automatic test_reset();
      ifa.send_en = 1'b0; ifa.data_in = '0;
      ifb.send_en = 1'b0; ifb.data_in = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      n_chk++;
      if ({a_srclk, a_rclk, a_ser, ifa.done, ifa.ready, a_clr} !== 6'b000011)
         $display("FAIL reset_a: srclk,rclk,ser,done,ready,srclr_n=%b required 000011", {a_srclk, a_rclk, a_ser, ifa.done, ifa.ready, a_clr});
      else n_pass++;
      n_chk++;
      if ({b_srclk, b_rclk, b_ser, ifb.done, ifb.ready, b_clr} !== 6'b000011)
         $display("FAIL reset_b: srclk,rclk,ser,done,ready,srclr_n=%b required 000011", {b_srclk, b_rclk, b_ser, ifb.done, ifb.ready, b_clr});
      else n_pass++;
      rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      n_chk++;
      if ({ifa.ready, ifa.done, a_rclk} !== 3'b100) $display("FAIL idle_a: ready,done,rclk=%b required 100", {ifa.ready, ifa.done, a_rclk});
      else n_pass++;
   endtask

   task automatic test_single();
      int t0, at;
      a_rw_q.delete(); a_rise_q.delete();
      a_rdy_fall = -1; a_rdy_rise = -1; a_clr_fall = -1; a_clr_rise = -1;
      @(negedge sys_clk);
      t0 = cyc;
      send_a(16'h7FC0);
      @(negedge sys_clk);
      ifa.send_en = 1'b0;
      ifa.data_in = 16'hFFFF;
      wait_done_a(400, at);
      @(negedge sys_clk);
      n_chk++;
      if (at != t0 + PA) $display("FAIL single_done: cycle %0d required %0d", at - t0, PA); else n_pass++;
      n_chk++;
      if (a_rw_q.size() != 1) $display("FAIL single_rclk_count: %0d pulses required 1", a_rw_q.size()); else n_pass++;
      n_chk++;
      if (((a_rw_q.size() > 0) ? a_rw_q[0] : -1) != 4) $display("FAIL single_rclk_width: %0d required 4", (a_rw_q.size() > 0) ? a_rw_q[0] : -1); else n_pass++;
      n_chk++;
      if (a_rdy_fall != t0 + 1 || a_rdy_rise != t0 + PA)
         $display("FAIL single_ready: low %0d..%0d required 1..%0d", a_rdy_fall - t0, a_rdy_rise - t0 - 1, PA - 1);
      else n_pass++;
      n_chk++;
      if (((a_rise_q.size() > 0) ? a_rise_q[0] - t0 : -1) != 5 + XA)
         $display("FAIL single_first_rise: T0+%0d required T0+%0d", (a_rise_q.size() > 0) ? a_rise_q[0] - t0 : -1, 5 + XA);
      else n_pass++;
      n_chk++;
      if (a_rise_q.size() != 16 || exp_a.size() != 0) $display("FAIL single_bits: %0d edges, %0d pending required 16, 0", a_rise_q.size(), exp_a.size());
      else n_pass++;
      n_chk++;
`ifdef HC595_SRCLR_EN
      if (a_clr_fall != t0 + 1 || a_clr_rise != t0 + 5) $display("FAIL single_srclr: low %0d..%0d required 1..4", a_clr_fall - t0, a_clr_rise - t0 - 1);
      else n_pass++;
`else
      if (a_clr_fall != -1) $display("FAIL single_srclr: fell at T0+%0d required never", a_clr_fall - t0);
      else n_pass++;
`endif
   endtask

   task automatic test_lsb();
      int t0, at = -1;
      logic [23:0] w = 24'hA50F3C;
      b_rw_q.delete(); b_nrise = 0;
      @(negedge sys_clk);
      t0 = cyc;
      ifb.data_in = w;
      ifb.send_en = 1'b1;
      for (int i = 0; i < 24; i++) exp_b.push_back(w[i]);
      @(negedge sys_clk);
      ifb.send_en = 1'b0;
      ifb.data_in = '0;
      for (int k = 0; k < 200 && at < 0; k++) begin
         @(negedge sys_clk);
         if (ifb.done) at = cyc;
      end
      @(negedge sys_clk);
      n_chk++;
      if (at != t0 + PB) $display("FAIL lsb_done: cycle %0d required %0d", at - t0, PB); else n_pass++;
      n_chk++;
      if (b_nrise != 24 || exp_b.size() != 0) $display("FAIL lsb_bits: %0d edges, %0d pending required 24, 0", b_nrise, exp_b.size()); else n_pass++;
      n_chk++;
      if (b_rw_q.size() != 1 || b_rw_q[0] != 1) $display("FAIL lsb_rclk: %0d pulses required 1 of width 1", b_rw_q.size()); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int t0;
      int d[3];
      @(negedge sys_clk);
      t0 = cyc;
      send_a(16'h0001);
      for (int f = 0; f < 3; f++) begin
         wait_done_a(400, d[f]);
         if (f < 2) send_a((f == 0) ? 16'h8000 : 16'h0001);
         else ifa.send_en = 1'b0;
      end
      @(negedge sys_clk);
      n_chk++;
      if (d[0] != t0 + PA) $display("FAIL b2b_first: cycle %0d required %0d", d[0] - t0, PA); else n_pass++;
      n_chk++;
      if (d[1] - d[0] != PA) $display("FAIL b2b_period1: %0d required %0d", d[1] - d[0], PA); else n_pass++;
      n_chk++;
      if (d[2] - d[1] != PA) $display("FAIL b2b_period2: %0d required %0d", d[2] - d[1], PA); else n_pass++;
      n_chk++;
      if (exp_a.size() != 0 || ifa.ready !== 1'b1) $display("FAIL b2b_end: %0d bits pending, ready=%b required 0, 1", exp_a.size(), ifa.ready); else n_pass++;
   endtask

   task automatic test_ignore();
      int t0, at = -1, ndone = 0;
      a_rw_q.delete();
      @(negedge sys_clk);
      t0 = cyc;
      send_a(16'hA5C3);
      while (cyc < t0 + PA + 30) begin
         @(negedge sys_clk);
         ifa.send_en = (cyc == t0 + 10 || cyc == t0 + 60);
         ifa.data_in = 16'h0F0F;
         if (ifa.done) begin ndone++; at = cyc; end
      end
      ifa.send_en = 1'b0;
      @(negedge sys_clk);
      n_chk++;
      if (ndone != 1 || at != t0 + PA) $display("FAIL ignore_done: %0d dones, last T0+%0d required 1 at T0+%0d", ndone, at - t0, PA); else n_pass++;
      n_chk++;
      if (a_rw_q.size() != 1 || exp_a.size() != 0) $display("FAIL ignore_rclk: %0d pulses, %0d bits pending required 1, 0", a_rw_q.size(), exp_a.size()); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int t0, at;
      a_rw_q.delete();
      @(negedge sys_clk);
      t0 = cyc;
      send_a(16'h3C5A);
      @(negedge sys_clk);
      ifa.send_en = 1'b0;
      while (cyc < t0 + 40) @(negedge sys_clk);
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({a_srclk, a_rclk, a_ser, ifa.done, ifa.ready, a_clr} !== 6'b000011)
         $display("FAIL midreset_async: srclk,rclk,ser,done,ready,srclr_n=%b required 000011", {a_srclk, a_rclk, a_ser, ifa.done, ifa.ready, a_clr});
      else n_pass++;
      exp_a.delete();
      @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      n_chk++;
      if (a_rw_q.size() != 0 || a_rw != 0 || ifa.ready !== 1'b1) $display("FAIL midreset_idle: %0d rclk pulses, ready=%b required 0, 1", a_rw_q.size(), ifa.ready);
      else n_pass++;
      t0 = cyc;
      send_a(16'hC3A5);
      @(negedge sys_clk);
      ifa.send_en = 1'b0;
      wait_done_a(400, at);
      @(negedge sys_clk);
      n_chk++;
      if (at != t0 + PA) $display("FAIL midreset_refr: done at %0d required %0d", at - t0, PA); else n_pass++;
      n_chk++;
      if (a_rw_q.size() != 1 || exp_a.size() != 0) $display("FAIL midreset_bits: %0d pulses, %0d pending required 1, 0", a_rw_q.size(), exp_a.size()); else n_pass++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_lsb();
      test_back_to_back();
      test_ignore();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
